// File: rtl/mux_sel_sched_if.sv
// mux_sel_sched_if: packet-source / symbol-mux side signals of the
// transmit symbol sequencer. fts_req is present only when
// MUX_SEL_SCHED_FTS_EN is defined.
interface mux_sel_sched_if #(
    parameter int LEN_W = 8
);
    logic             pkt_valid;
    logic [LEN_W-1:0] pkt_len;
    logic             abort;
`ifdef MUX_SEL_SCHED_FTS_EN
    logic             fts_req;
`endif
    logic [3:0]       sel;
    logic             pkt_ack;
    logic             data_rd;
    logic             busy;
    logic             skp_pending;

    modport master (
`ifdef MUX_SEL_SCHED_FTS_EN
        output fts_req,
`endif
        output pkt_valid, pkt_len, abort,
        input  sel, pkt_ack, data_rd, busy, skp_pending
    );

    modport slave (
`ifdef MUX_SEL_SCHED_FTS_EN
        input  fts_req,
`endif
        input  pkt_valid, pkt_len, abort,
        output sel, pkt_ack, data_rd, busy, skp_pending
    );
endinterface

// File: rtl/mux_sel_sched.sv
// mux_sel_sched: drives the 4-bit transmit symbol mux select, one symbol
// per clock. Frames packets as STP/payload/END, fills gaps with IDL,
// inserts COM+3xSKP ordered sets between packets every SKP_INTERVAL
// cycles and nullifies aborted packets with EDB.
// Optional FTS ordered sets (COM + N_FTS x FTS) are enabled by defining
// MUX_SEL_SCHED_FTS_EN.
module mux_sel_sched #(
    parameter int SKP_INTERVAL = 16,
    parameter int CNT_W        = 8,
    parameter int LEN_W        = 8
`ifdef MUX_SEL_SCHED_FTS_EN
    ,
    parameter int N_FTS        = 3
`endif
) (
    input logic            clk,
    input logic            reset_L,
    mux_sel_sched_if.slave bus
);
    localparam logic [3:0] SEL_DATA = 4'b0000;
    localparam logic [3:0] SEL_COM  = 4'b0001;
    localparam logic [3:0] SEL_SKP  = 4'b0011;
    localparam logic [3:0] SEL_STP  = 4'b0100;
    localparam logic [3:0] SEL_END  = 4'b0110;
    localparam logic [3:0] SEL_EDB  = 4'b0111;
    localparam logic [3:0] SEL_IDL  = 4'b1001;

`ifdef MUX_SEL_SCHED_FTS_EN
    localparam logic [3:0] SEL_FTS  = 4'b1000;
    localparam int SUB_W = ($clog2(N_FTS) > 2) ? $clog2(N_FTS) : 2;
    typedef enum logic [3:0] {
        S_IDLE, S_SKP_COM, S_SKP_SYM, S_STP, S_DATA, S_END, S_EDB,
        S_FTS_COM, S_FTS_SYM
    } state_t;
`else
    localparam int SUB_W = 2;
    typedef enum logic [2:0] {
        S_IDLE, S_SKP_COM, S_SKP_SYM, S_STP, S_DATA, S_END, S_EDB
    } state_t;
`endif

    state_t           state;
    state_t           nxt;
    state_t           decide;
    logic [CNT_W-1:0] skp_cnt;
    logic [LEN_W-1:0] bcnt;
    logic [SUB_W-1:0] sub_cnt;

    function automatic logic [3:0] sel_of(input state_t s);
        case (s)
            S_SKP_COM: return SEL_COM;
            S_SKP_SYM: return SEL_SKP;
            S_STP:     return SEL_STP;
            S_DATA:    return SEL_DATA;
            S_END:     return SEL_END;
            S_EDB:     return SEL_EDB;
`ifdef MUX_SEL_SCHED_FTS_EN
            S_FTS_COM: return SEL_COM;
            S_FTS_SYM: return SEL_FTS;
`endif
            default:   return SEL_IDL;
        endcase
    endfunction

    // Choice taken at a decision point (IDLE, END, end of an ordered set)
    always_comb begin
        if (bus.skp_pending)
            decide = S_SKP_COM;
`ifdef MUX_SEL_SCHED_FTS_EN
        else if (bus.fts_req)
            decide = S_FTS_COM;
`endif
        else if (bus.pkt_valid)
            decide = S_STP;
        else
            decide = S_IDLE;
    end

    // Next-state selection
    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE, S_END: nxt = decide;
            S_SKP_COM:     nxt = S_SKP_SYM;
            S_SKP_SYM:     nxt = (sub_cnt == '0) ? decide : S_SKP_SYM;
            S_STP:         nxt = (bcnt != '0) ? S_DATA : S_END;
            S_DATA: begin
                if (bus.abort)
                    nxt = S_EDB;
                else if (bcnt <= LEN_W'(1))
                    nxt = S_END;
                else
                    nxt = S_DATA;
            end
            S_EDB:         nxt = S_IDLE;
`ifdef MUX_SEL_SCHED_FTS_EN
            S_FTS_COM:     nxt = S_FTS_SYM;
            S_FTS_SYM:     nxt = (sub_cnt == '0) ? decide : S_FTS_SYM;
`endif
            default:       nxt = S_IDLE;
        endcase
    end

    // State, registered outputs and counters; outputs follow the state entered
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state           <= S_IDLE;
            bus.sel         <= SEL_IDL;
            bus.pkt_ack     <= 1'b0;
            bus.data_rd     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.skp_pending <= 1'b0;
            skp_cnt         <= '0;
            bcnt            <= '0;
            sub_cnt         <= '0;
        end else begin
            state       <= nxt;
            bus.sel     <= sel_of(nxt);
            bus.pkt_ack <= (nxt == S_STP);
            bus.data_rd <= (nxt == S_DATA);
            bus.busy    <= (nxt != S_IDLE);

            // a fresh expiry on the cycle SKP_COM starts keeps the debt owed
            if (nxt == S_SKP_COM)
                bus.skp_pending <= 1'b0;
            if (skp_cnt == CNT_W'(SKP_INTERVAL - 1)) begin
                skp_cnt         <= '0;
                bus.skp_pending <= 1'b1;
            end else begin
                skp_cnt <= skp_cnt + 1'b1;
            end

            if (nxt == S_STP)
                bcnt <= bus.pkt_len;
            else if (state == S_DATA)
                bcnt <= bcnt - 1'b1;

            if (state == S_SKP_COM)
                sub_cnt <= SUB_W'(2);
`ifdef MUX_SEL_SCHED_FTS_EN
            else if (state == S_FTS_COM)
                sub_cnt <= SUB_W'(N_FTS - 1);
`endif
            else if (sub_cnt != '0)
                sub_cnt <= sub_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_sel_sched.sv
// tb_mux_sel_sched: directed bench for mux_sel_sched (default build).
// A symbol-queue model predicts every output each cycle; literal symbol
// sequences pin the expected behaviour of each scenario.
module tb_mux_sel_sched;
    localparam int SKP_INTERVAL = 16;
    localparam logic [3:0] C_DATA = 4'b0000;
    localparam logic [3:0] C_COM  = 4'b0001;
    localparam logic [3:0] C_SKP  = 4'b0011;
    localparam logic [3:0] C_STP  = 4'b0100;
    localparam logic [3:0] C_END  = 4'b0110;
    localparam logic [3:0] C_EDB  = 4'b0111;
    localparam logic [3:0] C_IDL  = 4'b1001;

    logic clk     = 1'b0;
    logic reset_L = 1'b1;
    always #5 clk = ~clk;

    mux_sel_sched_if #(.LEN_W(8)) bus ();

    mux_sel_sched #(
        .SKP_INTERVAL(SKP_INTERVAL),
        .CNT_W       (8),
        .LEN_W       (8)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

`ifdef MUX_SEL_SCHED_FTS_EN
    initial bus.fts_req = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // model: cycle index since reset, current symbol, queued symbols
    int         k;
    logic [3:0] cur;
    logic [3:0] prev;
    logic [3:0] mq[$];
    bit         m_pend;
    int         didx;

    // source
    int src_q[$];
    int abort_at;
    bit abort_noise;

    // DUT history for literal checks
    logic [3:0] sel_log [0:63];
    bit         ack_log [0:63];
    bit         rd_log  [0:63];
    bit         pend_log[0:63];
    logic [3:0] el[$];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d actual=%b required=%b", nm, k, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d actual=%b required=%b", nm, k, act, exp);
        end
    endtask

    task automatic model_step();
        bit expire;
        bit took_skp;
        k++;
        expire   = ((k % SKP_INTERVAL) == 0);
        took_skp = 1'b0;
        prev     = cur;
        if (cur == C_DATA && bus.abort) begin
            mq.delete();
            mq.push_back(C_IDL);
            cur = C_EDB;
        end else if (mq.size() != 0) begin
            cur = mq.pop_front();
        end else if (m_pend) begin
            cur = C_COM;
            repeat (3) mq.push_back(C_SKP);
            took_skp = 1'b1;
        end else if (bus.pkt_valid) begin
            cur  = C_STP;
            didx = 0;
            for (int i = 0; i < int'(bus.pkt_len); i++) mq.push_back(C_DATA);
            mq.push_back(C_END);
        end else begin
            cur = C_IDL;
        end
        if (cur == C_DATA) didx++;
        m_pend = (m_pend && !took_skp) || expire;
    endtask

    task automatic compare();
        chk  ("sel",         bus.sel,         cur);
        chk_b("pkt_ack",     bus.pkt_ack,     cur == C_STP);
        chk_b("data_rd",     bus.data_rd,     cur == C_DATA);
        chk_b("busy",        bus.busy,        cur != C_IDL);
        chk_b("skp_pending", bus.skp_pending, m_pend);
    endtask

    task automatic apply();
        bus.pkt_valid = (src_q.size() != 0);
        bus.pkt_len   = (src_q.size() != 0) ? 8'(src_q[0]) : 8'd0;
        bus.abort     = ((cur == C_DATA) && (didx == abort_at)) ||
                        (abort_noise && (cur != C_DATA));
    endtask

    task automatic drive();
        if (prev == C_STP && src_q.size() != 0) void'(src_q.pop_front());
        apply();
    endtask

    task automatic push(input int len);
        src_q.push_back(len);
        apply();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (k < 64) begin
            sel_log[k]  = bus.sel;
            ack_log[k]  = bus.pkt_ack;
            rd_log[k]   = bus.data_rd;
            pend_log[k] = bus.skp_pending;
        end
        drive();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        chk  ("rst_sel",     bus.sel,         C_IDL);
        chk_b("rst_pkt_ack", bus.pkt_ack,     1'b0);
        chk_b("rst_data_rd", bus.data_rd,     1'b0);
        chk_b("rst_busy",    bus.busy,        1'b0);
        chk_b("rst_skp",     bus.skp_pending, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        k = 0; cur = C_IDL; prev = C_IDL; mq.delete(); m_pend = 1'b0; didx = 0;
        src_q.delete(); abort_at = 0; abort_noise = 1'b0;
        apply();
        reset_L = 1'b1;
    endtask

    task automatic ex(input logic [3:0] s, input int n);
        repeat (n) el.push_back(s);
    endtask

    task automatic lit_seq(input string nm, input int k0);
        for (int i = 0; i < el.size(); i++) begin
            n_chk++;
            if (sel_log[k0 + i] !== el[i]) begin
                n_fail++;
                $display("FAIL %s k=%0d sel=%b required=%b", nm, k0 + i, sel_log[k0 + i], el[i]);
            end
        end
        el.delete();
    endtask

    task automatic lit_cnt(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int cnt_ack(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(ack_log[i]);
        return c;
    endfunction

    function automatic int cnt_rd(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(rd_log[i]);
        return c;
    endfunction

    function automatic int cnt_sym(input int a, input int b, input logic [3:0] s);
        int c = 0;
        for (int i = a; i <= b; i++) c += (sel_log[i] == s) ? 1 : 0;
        return c;
    endfunction

    initial begin
        bus.pkt_valid = 1'b0;
        bus.pkt_len   = 8'd0;
        bus.abort     = 1'b0;
        cur = C_IDL; prev = C_IDL; k = 0; m_pend = 1'b0; didx = 0;
        abort_at = 0; abort_noise = 1'b0;
        #2;

        // idle: periodic SKP ordered sets every 16 cycles
        do_reset();
        repeat (40) tick();
        ex(C_IDL, 16); ex(C_COM, 1); ex(C_SKP, 3); ex(C_IDL, 12);
        ex(C_COM, 1); ex(C_SKP, 3); ex(C_IDL, 1);
        lit_seq("idle_skp", 1);
        lit_cnt("pend_k15", int'(pend_log[15]), 0);
        lit_cnt("pend_k16", int'(pend_log[16]), 1);
        lit_cnt("pend_k17", int'(pend_log[17]), 0);

        // single 4-byte packet, abort toggling outside DATA
        do_reset();
        abort_noise = 1'b1;
        push(4);
        repeat (8) tick();
        ex(C_STP, 1); ex(C_DATA, 4); ex(C_END, 1); ex(C_IDL, 2);
        lit_seq("pkt4", 1);
        lit_cnt("pkt4_acks", cnt_ack(1, 8), 1);
        lit_cnt("pkt4_rds", cnt_rd(1, 8), 4);

        // back-to-back len 2 then empty packet
        do_reset();
        push(2);
        push(0);
        repeat (8) tick();
        ex(C_STP, 1); ex(C_DATA, 2); ex(C_END, 1); ex(C_STP, 1); ex(C_END, 1); ex(C_IDL, 2);
        lit_seq("b2b", 1);
        lit_cnt("b2b_acks", cnt_ack(1, 8), 2);

        // len 6 aborted on 3rd byte, next packet waits behind the IDL after EDB
        do_reset();
        abort_at = 3;
        push(6);
        push(1);
        repeat (11) tick();
        ex(C_STP, 1); ex(C_DATA, 3); ex(C_EDB, 1); ex(C_IDL, 1);
        ex(C_STP, 1); ex(C_DATA, 1); ex(C_END, 1); ex(C_IDL, 2);
        lit_seq("abort3", 1);
        lit_cnt("abort3_rds", cnt_rd(1, 6), 3);
        lit_cnt("abort3_no_end", cnt_sym(1, 6, C_END), 0);

        // abort on the final byte
        do_reset();
        abort_at = 2;
        push(2);
        repeat (6) tick();
        ex(C_STP, 1); ex(C_DATA, 2); ex(C_EDB, 1); ex(C_IDL, 2);
        lit_seq("abort_last", 1);

        // SKP expiry inside a 10-byte packet is deferred until after END
        do_reset();
        repeat (8) tick();
        push(10);
        push(1);
        repeat (22) tick();
        ex(C_STP, 1); ex(C_DATA, 10); ex(C_END, 1); ex(C_COM, 1); ex(C_SKP, 3);
        ex(C_STP, 1); ex(C_DATA, 1); ex(C_END, 1); ex(C_IDL, 1);
        lit_seq("skp_defer", 9);
        lit_cnt("defer_pend_k19", int'(pend_log[19]), 1);

        // asynchronous reset mid-DATA, then a clean full-length restart
        do_reset();
        push(5);
        repeat (3) tick();
        do_reset();
        push(5);
        repeat (8) tick();
        ex(C_STP, 1); ex(C_DATA, 5); ex(C_END, 1); ex(C_IDL, 1);
        lit_seq("restart", 1);
        lit_cnt("restart_rds", cnt_rd(1, 8), 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_sel_sched.md
Name: mux_sel_sched

Overview:
- Sequencer that drives the 4-bit select of the transmit symbol mux, one symbol per clock.
- Frames upstream packets as STP, payload bytes, END.
- Fills gaps with IDL.
- Inserts periodic SKP ordered sets (COM + 3×SKP) between packets.
- Nullifies aborted packets with EDB.
- Sits between the packet source and the symbol mux; the payload byte goes straight to the mux data input whenever sel = 4'b0000.

Parameters:
- SKP_INTERVAL, 16, cycles between SKP ordered-set requests; legal range 8..2^CNT_W-1.
- CNT_W, 8, width of the SKP interval counter.
- LEN_W, 8, width of pkt_len.

Ports:
- clk  in  1  symbol clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous active-low reset.
- pkt_valid  in  1  packet waiting; held high with pkt_len stable until pkt_ack.
- pkt_len  in  LEN_W  payload byte count of the pending packet.
- abort  in  1  kill the current packet; sampled only in DATA.
- sel  out  4  mux select (registered).
- pkt_ack  out  1  one-cycle pulse; packet accepted.
- data_rd  out  1  high exactly when sel = 4'b0000; source presents the next payload byte that cycle and advances.
- busy  out  1  high in any state other than IDLE.
- skp_pending  out  1  SKP ordered set owed, not yet started.

Behaviour:
- Select encoding (fixed):
  - DATA 0000, COM 0001, PAD 0010, SKP 0011, STP 0100, SDP 0101, END 0110, EDB 0111, FTS 1000, IDL 1001.
  - PAD and SDP are never generated.
- Reset (async, reset_L=0):
  - state=IDLE, sel=4'b1001, pkt_ack=0, data_rd=0, busy=0, skp_pending=0.
  - SKP counter=0, byte counter=0.
  - Reset mid-packet discards the packet with no END/EDB emitted.
- All outputs are registered; sel reflects the current state.
- States: IDLE, SKP_COM, SKP_SYM, STP, DATA, END, EDB.
  - FTS_COM and FTS_SYM are added with the optional feature.
- SKP counter:
  - Increments every cycle; wraps to 0 and sets skp_pending when it reaches SKP_INTERVAL-1.
  - skp_pending clears on entering SKP_COM.
  - A second expiry while pending is lost; pending stays 1, no queueing.
- Decision point is IDLE or END. Next state priority:
  - skp_pending -> SKP_COM.
  - Else pkt_valid -> STP.
  - Else -> IDLE.
  - Back-to-back packets therefore have no IDL gap.
- SKP_COM: 1 cycle, then SKP_SYM.
- SKP_SYM: exactly 3 cycles (sub-counter), then the decision point.
- STP:
  - pkt_ack=1 this cycle only; pkt_len is latched into the byte counter.
  - Next state is DATA if pkt_len != 0, else END (empty packet STP,END is legal).
- DATA:
  - One byte per cycle, data_rd=1; byte counter decrements.
  - Leave after the final byte: latched length L gives exactly L DATA cycles.
  - SKP is never inserted inside a packet; skp_pending may rise during DATA and is serviced after END.
- abort:
  - abort=1 sampled in any DATA cycle: that byte is still consumed; the next state is EDB instead of DATA/END.
  - abort on the final byte also yields EDB.
  - abort outside DATA is ignored.
- END and EDB: 1 cycle each.
  - END goes to the decision point.
  - EDB goes to IDLE for at least 1 cycle.
- pkt_valid dropping before pkt_ack is a protocol violation; behaviour is unspecified, but the FSM must not lock up.
- busy=0 only in IDLE.

Optional Feature:
- MUX_SEL_SCHED_FTS_EN
- Defined:
  - Adds input fts_req (1 bit) and parameter N_FTS (default 3).
  - At the decision point, priority is skp_pending > fts_req > pkt_valid.
  - fts_req emits COM (FTS_COM), then N_FTS cycles of FTS 4'b1000, then the decision point.
  - fts_req is level-sensitive and re-evaluated after each sequence.
- Undefined: port, parameter and states are absent; sel never equals 4'b1000.

Test Plan:
- Reset, no requests, SKP_INTERVAL=16 -> sel=1001 until cycle 15; skp_pending=1; then 0001, 0011×3, back to 1001; repeats every 16 cycles.
- pkt_valid=1, pkt_len=4 in IDLE (no SKP due) -> sel sequence 0100 (pkt_ack=1), 0000×4 (data_rd=1 each), 0110, 1001.
- Two queued packets, len 2 then len 0 -> 0100,0000,0000,0110,0100,0110,1001 with exactly 2 pkt_ack pulses, no IDL between.
- len 6 with abort on 3rd DATA cycle -> 0100, 0000×3, 0111, 1001; no 0110; 3 data_rd pulses.
- SKP expiry during a 10-byte packet -> no 0001/0011 inside the packet; after 0110: 0001, 0011×3, then next packet's 0100.
- reset_L low during DATA -> sel=1001 and all outputs 0 immediately (asynchronous); after release, the next pkt_valid restarts at STP with a full-length transfer.
